fpu_pipe: RTL and testbench

FPU_PIPE -- requirements
Module: fpu_pipe

---
 rtl/fpu_pipe.sv | 274 +++++++++++++++++++++++++++
 tb/tb_fpu_pipe.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fpu_pipe.sv
// fpu_pipe: single-issue floating-point ADD/SUB/MUL/DIV with hidden bit, one guard bit and truncation.
// Define FPU_PIPE_DENORM_EN to compile in gradual-underflow (denormal input and output) support.
module fpu_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] A,
    input  logic [EXP_W+MAN_W:0] B,
    input  logic [1:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] O,
    output logic [3:0]           flags
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int PW  = 2 * MAN_W + 2;
    localparam int XW  = EXP_W + 4;
    localparam int LZW = $clog2(PW + 1);
    localparam int CW  = $clog2(MAN_W + 3);

    localparam logic signed [XW-1:0] E_ONE   = XW'(1);
    localparam logic signed [XW-1:0] BIAS_X  = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX_X  = XW'((1 << EXP_W) - 2);
    localparam logic signed [XW-1:0] ALIGN_X = XW'(MAN_W + 2);
`ifdef FPU_PIPE_DENORM_EN
    localparam logic signed [XW-1:0] PW_X    = XW'(PW);
`endif

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_INV  = 4'b1000;
    localparam logic [3:0] F_DZ   = 4'b0100;
    localparam logic [3:0] F_OVF  = 4'b0010;
    localparam logic [3:0] F_UNF  = 4'b0001;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DIV, DONE} state_t;

    typedef struct packed {
        logic                 sign;
        logic                 zero;
        logic                 inf;
        logic                 nan;
        logic signed [XW-1:0] exp;
        logic [MAN_W:0]       man;
    } unpacked_t;

    typedef struct packed {
        logic [3:0]   flags;
        logic [W-1:0] word;
    } result_t;

    function automatic logic [LZW-1:0] lzc(input logic [PW-1:0] v);
        lzc = LZW'(PW);
        for (int i = 0; i < PW; i++)
            if (v[i]) lzc = LZW'(PW - 1 - i);
    endfunction

    // Every finite nonzero operand leaves here with its leading one at man[MAN_W].
    function automatic unpacked_t unpack(input logic [W-1:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        unpacked_t        u;
        e      = x[W-2 -: EXP_W];
        f      = x[MAN_W-1:0];
        u.sign = x[W-1];
        u.nan  = (&e) && (|f);
        u.inf  = (&e) && !(|f);
`ifdef FPU_PIPE_DENORM_EN
        if (e == '0) begin
            logic [LZW-1:0] lz;
            lz     = lzc({1'b0, f, {(PW-MAN_W-1){1'b0}}});
            u.zero = !(|f);
            u.man  = {1'b0, f} << lz;
            u.exp  = E_ONE - XW'(lz);
        end else begin
            u.zero = 1'b0;
            u.man  = {1'b1, f};
            u.exp  = XW'(e);
        end
`else
        u.zero = (e == '0);
        u.man  = {1'b1, f};
        u.exp  = XW'(e);
`endif
        return u;
    endfunction

    // v is read as v / 2^(PW-1) * 2^(e - bias); normalise, then saturate or underflow.
    function automatic result_t pack(input logic sign, input logic signed [XW-1:0] e,
                                     input logic [PW-1:0] v);
        logic [LZW-1:0]       lz;
        logic [PW-1:0]        nv;
        logic signed [XW-1:0] er;
        result_t              r;
`ifdef FPU_PIPE_DENORM_EN
        logic signed [XW-1:0] sh;
        logic [PW-1:0]        dv;
`endif
        lz = lzc(v);
        nv = v << lz;
        er = e - XW'(lz);
        if (er > EMAX_X) begin
            r.flags = F_OVF;
            r.word  = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (er >= E_ONE) begin
            r.flags = F_NONE;
            r.word  = {sign, er[EXP_W-1:0], nv[PW-2 -: MAN_W]};
        end else begin
`ifdef FPU_PIPE_DENORM_EN
            sh      = E_ONE - er;
            dv      = (sh >= PW_X) ? '0 : (nv >> sh);
            r.flags = F_UNF;
            r.word  = {sign, {EXP_W{1'b0}}, dv[PW-2 -: MAN_W]};
`else
            r.flags = F_UNF;
            r.word  = {sign, {(W-1){1'b0}}};
`endif
        end
        return r;
    endfunction

    function automatic logic is_special(input logic [W-1:0] x);
`ifdef FPU_PIPE_DENORM_EN
        return (&x[W-2 -: EXP_W]) || (x[W-2:0] == '0);
`else
        return (&x[W-2 -: EXP_W]) || (x[W-2 -: EXP_W] == '0);
`endif
    endfunction

    state_t               state;
    logic [W-1:0]         a_q, b_q;
    logic [1:0]           op_q;
    logic [CW-1:0]        cnt_q;
    logic [MAN_W+1:0]     rem_q, quo_q;

    unpacked_t            ua, ub;
    logic                 sb_eff, s_xor, swap, s_big, s_small;
    logic signed [XW-1:0] big_exp, small_exp, d;
    logic [MAN_W:0]       big_man, small_man;
    logic [MAN_W+1:0]     m_small;
    logic [MAN_W+2:0]     sum;
    logic [PW-1:0]        prod;
    logic [MAN_W+1:0]     rem_cur, rem_nxt;
    logic                 div_ge, div_special;
    result_t              calc_res, div_res;

    assign in_ready    = (state == IDLE) && !rst;
    assign div_special = is_special(A) || is_special(B);

    // NOTE: every always_comb output is assigned before any branch reads it, so no latch is inferred.
    always_comb begin
        ua      = unpack(a_q);
        ub      = unpack(b_q);
        sb_eff  = ub.sign ^ (op_q == OP_SUB);
        s_xor   = ua.sign ^ ub.sign;

        swap      = (ub.exp > ua.exp) || ((ub.exp == ua.exp) && (ub.man > ua.man));
        big_exp   = swap ? ub.exp : ua.exp;
        big_man   = swap ? ub.man : ua.man;
        small_exp = swap ? ua.exp : ub.exp;
        small_man = swap ? ua.man : ub.man;
        s_big     = swap ? sb_eff : ua.sign;
        s_small   = swap ? ua.sign : sb_eff;
        d         = big_exp - small_exp;
        m_small   = (d >= ALIGN_X) ? '0 : ({small_man, 1'b0} >> d);
        sum       = (s_big == s_small) ? ({1'b0, big_man, 1'b0} + {1'b0, m_small})
                                       : ({1'b0, big_man, 1'b0} - {1'b0, m_small});
        prod      = PW'(ua.man) * PW'(ub.man);

        // First divider step starts from the dividend mantissa rather than the stale remainder.
        rem_cur = (cnt_q == '0) ? {1'b0, ua.man} : rem_q;
        div_ge  = rem_cur >= {1'b0, ub.man};
        rem_nxt = (div_ge ? (rem_cur - {1'b0, ub.man}) : rem_cur) << 1;
        div_res = pack(s_xor, ua.exp - ub.exp + BIAS_X, {quo_q, {(PW-MAN_W-2){1'b0}}});

        calc_res.flags = F_NONE;
        calc_res.word  = '0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                if (ua.nan || ub.nan) calc_res.word = QNAN;
                else if (ua.inf && ub.inf) begin
                    if (ua.sign != sb_eff) begin
                        calc_res.flags = F_INV;
                        calc_res.word  = QNAN;
                    end else calc_res.word = {ua.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end
                else if (ua.inf) calc_res.word = {ua.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                else if (ub.inf) calc_res.word = {sb_eff, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                else if (ua.zero && ub.zero) calc_res.word = '0;
                else if (ua.zero) calc_res.word = {sb_eff, b_q[W-2:0]};
                else if (ub.zero) calc_res.word = a_q;
                else if (sum == '0) calc_res.word = '0;
                else calc_res = pack(s_big, big_exp + E_ONE, {sum, {(PW-MAN_W-3){1'b0}}});
            end
            OP_MUL: begin
                if (ua.nan || ub.nan) calc_res.word = QNAN;
                else if ((ua.zero && ub.inf) || (ua.inf && ub.zero)) begin
                    calc_res.flags = F_INV;
                    calc_res.word  = QNAN;
                end
                else if (ua.inf || ub.inf) calc_res.word = {s_xor, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                else if (ua.zero || ub.zero) calc_res.word = {s_xor, {(W-1){1'b0}}};
                else calc_res = pack(s_xor, ua.exp + ub.exp - BIAS_X + E_ONE, prod);
            end
            default: begin
                if (ua.nan || ub.nan) calc_res.word = QNAN;
                else if ((ua.zero && ub.zero) || (ua.inf && ub.inf)) begin
                    calc_res.flags = F_INV;
                    calc_res.word  = QNAN;
                end
                else if (ua.inf) calc_res.word = {s_xor, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                else if (ub.inf) calc_res.word = {s_xor, {(W-1){1'b0}}};
                else if (ub.zero) begin
                    calc_res.flags = F_DZ;
                    calc_res.word  = {s_xor, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end
                else if (ua.zero) calc_res.word = {s_xor, {(W-1){1'b0}}};
                else calc_res = div_res;
            end
        endcase
    end

    // NOTE: registers use <= so each one samples the values from before the clock edge.
    // NOTE: operand and divider registers are not reset; only control state and visible outputs need known values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            O         <= '0;
            flags     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q   <= A;
                    b_q   <= B;
                    op_q  <= opcode;
                    cnt_q <= '0;
                    state <= (opcode == OP_DIV && !div_special) ? DIV : CALC;
                end
                CALC: begin
                    O         <= calc_res.word;
                    flags     <= calc_res.flags;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DIV: if (cnt_q == CW'(MAN_W + 2)) begin
                    O         <= div_res.word;
                    flags     <= div_res.flags;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end else begin
                    rem_q <= rem_nxt;
                    quo_q <= {quo_q[MAN_W:0], div_ge};
                    cnt_q <= cnt_q + CW'(1);
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_pipe.sv
// tb_fpu_pipe: directed-vector bench for fpu_pipe at W=32 with hand-computed expected results.
module tb_fpu_pipe;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A, B;
    logic [1:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] O;
    logic [3:0]  flags;

    int passed = 0;
    int total  = 0;

    fpu_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .opcode   (opcode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .O        (O),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one operation, wait for the result, check it, then complete the handshake.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] exp_o,
                          input logic [3:0] exp_f, input int exp_lat);
        int n;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        A = a; B = b; opcode = op; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_O"}, O, exp_o);
        check({tag, "_flags"}, 32'(flags), 32'(exp_f));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_out_valid_clr"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; opcode = OP_ADD;

        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_O", O, 32'h0);
        check("rst_flags", 32'(flags), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", 32'(in_ready), 32'd1);

        run_op("add_basic", 32'h3FC00000, 32'h40100000, OP_ADD, 32'h40700000, 4'b0000, 2);
        run_op("mul_basic", 32'h40400000, 32'h40000000, OP_MUL, 32'h40C00000, 4'b0000, 2);
        run_op("mul_ovf",   32'h7F000000, 32'h40000000, OP_MUL, 32'h7F800000, 4'b0010, 2);
        run_op("div_basic", 32'h40C00000, 32'h40000000, OP_DIV, 32'h40400000, 4'b0000, 27);
        run_op("div_zero",  32'h3F800000, 32'h00000000, OP_DIV, 32'h7F800000, 4'b0100, 2);
        run_op("sub_infinf",32'h7F800000, 32'h7F800000, OP_SUB, 32'h7FC00000, 4'b1000, 2);
        run_op("sub_exact0",32'h3F800000, 32'h3F800000, OP_SUB, 32'h00000000, 4'b0000, 2);
        run_op("sub_lzshift",32'h3F800000,32'h3F7FFFFF, OP_SUB, 32'h33800000, 4'b0000, 2);
        run_op("div_trunc", 32'h3F800000, 32'h40400000, OP_DIV, 32'h3EAAAAAA, 4'b0000, 27);
        run_op("add_nan",   32'h7FC12345, 32'h3F800000, OP_ADD, 32'h7FC00000, 4'b0000, 2);
        run_op("add_ovf",   32'h7F7FFFFF, 32'h7F7FFFFF, OP_ADD, 32'h7F800000, 4'b0010, 2);
        run_op("mul_unf",   32'h00800000, 32'h3F000000, OP_MUL, 32'h00000000, 4'b0001, 2);

        // Back-pressure: result must hold while a new request is presented and ignored.
        A = 32'h3FC00000; B = 32'h40100000; opcode = OP_ADD; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        check("bp_latency", 32'(n), 32'd2);
        for (int i = 0; i < 5; i++) begin
            A = 32'h40000000; B = 32'h40000000; opcode = OP_MUL; in_valid = 1'b1;
            tick();
            check("bp_O_hold", O, 32'h40700000);
            check("bp_flags_hold", 32'(flags), 32'd0);
            check("bp_out_valid_hold", 32'(out_valid), 32'd1);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_out_valid_clr", 32'(out_valid), 32'd0);
        check("bp_in_ready_back", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("bp_ignored_req", 32'(seen), 32'd0);

        // Reset during a divide: the operation is dropped and no result appears.
        A = 32'h40C00000; B = 32'h40000000; opcode = OP_DIV; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        seen = 0;
        while (n < 10) begin
            tick();
            n++;
            if (out_valid) seen++;
        end
        rst = 1'b1;
        #1;
        check("rstdiv_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rstdiv_in_ready", 32'(in_ready), 32'd1);
        check("rstdiv_O_cleared", O, 32'h0);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("rstdiv_no_result", 32'(seen), 32'd0);
        run_op("rstdiv_add", 32'h3FC00000, 32'h40100000, OP_ADD, 32'h40700000, 4'b0000, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
